trs_dn_arbiter: RTL and testbench
=================================

TRS_DN_ARBITER -- requirements
Module: trs_dn_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4: entries per requester FIFO; power of two, at least 2.
REQ-002 SHALL have parameter WR_GAP, default 3: idle cycles after each dn_wr strobe; at least 1.
REQ-003 SHALL have port clk_sys  in  1  system clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port a_active  in  1  requester A (CMD loader) download in progress.
REQ-006 SHALL have port a_wr  in  1  A write strobe, one byte per high cycle.
REQ-007 SHALL have port a_addr  in  16  A CPU address.
REQ-008 SHALL have port a_data  in  8  A byte.
REQ-009 SHALL have port a_exec  in  1  A execute-request pulse.
REQ-010 SHALL have port a_exec_addr  in  16  execute address, sampled with a_exec.
REQ-011 SHALL have port a_wait  out  1  A backpressure.
REQ-012 SHALL have port b_active  in  1  requester B (raw ioctl) download in progress.
REQ-013 SHALL have port b_wr  in  1  B write strobe.
REQ-014 SHALL have port b_sel  in  1  B target: 0 CPU space, 1 cassette space.
REQ-015 SHALL have port b_addr  in  16  B address.
REQ-016 SHALL have port b_data  in  8  B byte.
REQ-017 SHALL have port b_wait  out  1  B backpressure.
REQ-018 SHALL have port dn_busy  in  1  RAM side cannot accept a strobe this cycle.
REQ-019 SHALL have port dn_go  out  1  download window to machine core.
REQ-020 SHALL have port dn_wr  out  1  one-cycle RAM write strobe.
REQ-021 SHALL have port dn_addr  out  24  RAM address.
REQ-022 SHALL have port dn_data  out  8  RAM byte.
REQ-023 SHALL have port execute_enable  out  1  one-cycle jump pulse to core.
REQ-024 SHALL have port execute_addr  out  16  jump target, valid with execute_enable and held after.

Function
REQ-025 Each requester SHALL own a DEPTH-entry FIFO; x_wr pushes {addr,data[,sel]}; pushed entry becomes eligible for grant the following cycle.
REQ-026 x_wait SHALL be registered, high when that FIFO holds at least DEPTH-1 entries.
REQ-027 x_wr on a full FIFO with no same-cycle pop SHALL drop the byte and leave the FIFO unchanged; simultaneous push and pop when full SHALL succeed.
REQ-028 FSM states: IDLE, ISSUE, GAP; GAP counter counts WR_GAP cycles.
REQ-029 IDLE -> ISSUE when any FIFO is non-empty and dn_busy=0; otherwise stay in IDLE.
REQ-030 ISSUE SHALL last exactly one cycle: dn_wr=1, FIFO head popped, dn_addr/dn_data registered from the granted head; then -> GAP.
REQ-031 Last GAP cycle SHALL go directly to ISSUE if the IDLE->ISSUE condition holds, else -> IDLE; minimum strobe spacing is WR_GAP+1 cycles.
REQ-032 Arbitration SHALL be round-robin: with both FIFOs non-empty, grant the requester not granted last; a single non-empty FIFO is granted regardless of history.
REQ-033 dn_addr SHALL be {8'h00,a_addr} for A grants and {7'h00,b_sel,b_addr} for B grants; dn_addr/dn_data hold between strobes.
REQ-034 dn_go SHALL be registered: high the cycle after any of a_active, b_active, FIFO non-empty, or state!=IDLE is true; low the cycle after all are false.
REQ-035 a_exec SHALL set exec_pend and capture a_exec_addr; a second a_exec while pending SHALL overwrite the address.
REQ-036 execute_enable SHALL pulse one cycle when exec_pend=1, dn_go=0 and a_active=b_active=0; exec_pend clears on that cycle; execute_addr updates on the same edge.

Reset
REQ-037 While reset=1: FIFOs flushed, FSM IDLE, GAP counter 0, last-grant=B (A wins first tie), exec_pend=0, all outputs 0; a reset mid-transfer discards pending bytes and any pending execute.

Verification
REQ-038 A only: a_active=1, write 0x42 to 0x4000 -> dn_wr one cycle, dn_addr=0x004000, dn_data=0x42, dn_go high.
REQ-039 B cassette: b_sel=1, b_addr=0x0010, data 0xA5 -> dn_addr=0x010010.
REQ-040 Both FIFOs holding 3 bytes -> strobes alternate A,B,A,B,A,B, exactly WR_GAP+1=4 cycles apart.
REQ-041 A pushes every cycle with DEPTH=4 -> a_wait rises after third entry; 5th push while full is dropped and never appears on dn_wr.
REQ-042 dn_busy=1 for 10 cycles with pending data -> no dn_wr during the hold; first strobe 1 cycle after release.
REQ-043 a_exec with addr 0x5200 during transfer -> execute_enable only after last strobe, dn_go=0, and both actives low; execute_addr=0x5200.

Source files
------------

// File: rtl/trs_dn_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : trs_dn_arbiter
// Purpose  : Merges two byte-download requesters into one RAM write port.
//            The CMD loader (A) and the raw ioctl path (B) each get a small
//            FIFO. A three-state issue engine drains the FIFOs round-robin
//            and spaces the one-cycle RAM strobes WR_GAP idle cycles apart.
//            A deferred execute request from A is released only after both
//            downloads have finished and the download window has closed.
// Ports    : clk_sys, reset             - clock, async active-high reset
//            a_active/a_wr/a_addr/a_data - requester A download stream
//            a_exec/a_exec_addr          - A execute request and jump target
//            b_active/b_wr/b_sel/b_addr/b_data - requester B download stream
//            a_wait/b_wait               - per-requester backpressure
//            dn_busy                     - RAM side cannot take a strobe
//            dn_go/dn_wr/dn_addr/dn_data - download window and RAM write
//            execute_enable/execute_addr - jump pulse and target to core
// Revision : 1.0 - initial release
// ============================================================================
module trs_dn_arbiter #(
    parameter int DEPTH  = 4,
    parameter int WR_GAP = 3
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        a_active,
    input  logic        a_wr,
    input  logic [15:0] a_addr,
    input  logic [7:0]  a_data,
    input  logic        a_exec,
    input  logic [15:0] a_exec_addr,
    output logic        a_wait,
    input  logic        b_active,
    input  logic        b_wr,
    input  logic        b_sel,
    input  logic [15:0] b_addr,
    input  logic [7:0]  b_data,
    output logic        b_wait,
    input  logic        dn_busy,
    output logic        dn_go,
    output logic        dn_wr,
    output logic [23:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        execute_enable,
    output logic [15:0] execute_addr
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_GAP_W = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
    localparam int c_ENT_W = 25;  // {sel, addr[15:0], data[7:0]}

    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_WAIT_LVL = c_CNT_W'(DEPTH - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(WR_GAP - 1);

    // Index 0 is requester A, index 1 is requester B.
    logic [1:0]         wr_in;
    logic [c_ENT_W-1:0] ent_in [2];
    logic [c_ENT_W-1:0] head   [2];
    logic [1:0]         pop;
    logic [1:0]         not_empty;
    logic [1:0]         x_wait;

    assign wr_in     = {b_wr, a_wr};
    // A always targets CPU space, so its select bit is tied low.
    assign ent_in[0] = {1'b0, a_addr, a_data};
    assign ent_in[1] = {b_sel, b_addr, b_data};

    generate
        for (genvar r = 0; r < 2; r++) begin : g_fifo
            logic [c_ENT_W-1:0] mem_q [DEPTH];
            logic [c_PTR_W-1:0] rd_ptr_q;
            logic [c_PTR_W-1:0] wr_ptr_q;
            logic [c_CNT_W-1:0] cnt_q;
            logic [c_CNT_W-1:0] cnt_d;
            logic               wait_q;
            logic               push;

            // A full FIFO still accepts a byte when its head leaves this cycle.
            assign push = wr_in[r] && ((cnt_q != c_FULL) || pop[r]);

            always_comb begin
                cnt_d = cnt_q;
                if (push && !pop[r]) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (!push && pop[r]) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            always_ff @(posedge clk_sys or posedge reset) begin
                if (reset) begin
                    rd_ptr_q <= '0;
                    wr_ptr_q <= '0;
                    cnt_q    <= '0;
                    wait_q   <= 1'b0;
                end else begin
                    if (push) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                    end
                    if (pop[r]) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                    end
                    cnt_q  <= cnt_d;
                    // Raised one entry early so a requester sampling it late
                    // still has a free slot for its in-flight byte.
                    wait_q <= (cnt_d >= c_WAIT_LVL);
                end
            end

            always_ff @(posedge clk_sys) begin
                if (push) begin
                    mem_q[wr_ptr_q] <= ent_in[r];
                end
            end

            assign head[r]      = mem_q[rd_ptr_q];
            assign not_empty[r] = (cnt_q != '0);
            assign x_wait[r]    = wait_q;
        end
    endgenerate

    assign a_wait = x_wait[0];
    assign b_wait = x_wait[1];

    // ------------------------------------------------------------------
    // Issue engine
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             state_q;
    logic [c_GAP_W-1:0] gap_cnt_q;
    logic               last_b_q;
    logic               dn_wr_q;
    logic [23:0]        dn_addr_q;
    logic [7:0]         dn_data_q;

    logic               any_pend;
    logic               issue;
    logic               grant_a;
    logic [c_ENT_W-1:0] gnt_ent;

    assign any_pend = |not_empty;
    // Issue decision is taken on the edge that enters ISSUE, so the strobe
    // cycle itself already presents the registered head.
    assign issue    = any_pend && !dn_busy &&
                      ((state_q == ST_IDLE) ||
                       ((state_q == ST_GAP) && (gap_cnt_q == c_GAP_LAST)));
    assign grant_a  = not_empty[0] && (!not_empty[1] || last_b_q);
    assign gnt_ent  = grant_a ? head[0] : head[1];
    assign pop[0]   = issue && grant_a;
    assign pop[1]   = issue && !grant_a;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
            last_b_q  <= 1'b1;
            dn_wr_q   <= 1'b0;
            dn_addr_q <= '0;
            dn_data_q <= '0;
        end else begin
            dn_wr_q <= issue;
            if (issue) begin
                dn_addr_q <= {7'h00, gnt_ent[24], gnt_ent[23:8]};
                dn_data_q <= gnt_ent[7:0];
                last_b_q  <= !grant_a;
            end
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_q   <= ST_GAP;
                    gap_cnt_q <= '0;
                end
                ST_GAP: begin
                    if (gap_cnt_q == c_GAP_LAST) begin
                        gap_cnt_q <= '0;
                        state_q   <= issue ? ST_ISSUE : ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dn_wr   = dn_wr_q;
    assign dn_addr = dn_addr_q;
    assign dn_data = dn_data_q;

    // ------------------------------------------------------------------
    // Download window and deferred execute
    // ------------------------------------------------------------------
    logic        dn_go_q;
    logic        exec_pend_q;
    logic [15:0] exec_addr_q;
    logic        exec_en_q;
    logic [15:0] exec_out_q;
    logic        fire;

    assign fire = exec_pend_q && !dn_go_q && !a_active && !b_active;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dn_go_q     <= 1'b0;
            exec_pend_q <= 1'b0;
            exec_addr_q <= '0;
            exec_en_q   <= 1'b0;
            exec_out_q  <= '0;
        end else begin
            dn_go_q   <= a_active || b_active || any_pend || (state_q != ST_IDLE);
            exec_en_q <= fire;
            if (fire) begin
                exec_out_q <= exec_addr_q;
            end
            // A fresh request wins over a release in the same cycle.
            if (a_exec) begin
                exec_pend_q <= 1'b1;
                exec_addr_q <= a_exec_addr;
            end else if (fire) begin
                exec_pend_q <= 1'b0;
            end
        end
    end

    assign dn_go          = dn_go_q;
    assign execute_enable = exec_en_q;
    assign execute_addr   = exec_out_q;

endmodule
`default_nettype wire

// File: tb/tb_trs_dn_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_trs_dn_arbiter
// Purpose  : Self-checking bench for trs_dn_arbiter. A queue-based reference
//            model predicts every output each cycle; directed phases add
//            literal expectations for addresses, ordering and timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trs_dn_arbiter;

    localparam int DEPTH  = 4;
    localparam int WR_GAP = 3;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b0;
    logic        a_active, a_wr, a_exec;
    logic [15:0] a_addr, a_exec_addr;
    logic [7:0]  a_data;
    logic        a_wait;
    logic        b_active, b_wr, b_sel;
    logic [15:0] b_addr;
    logic [7:0]  b_data;
    logic        b_wait;
    logic        dn_busy;
    logic        dn_go, dn_wr;
    logic [23:0] dn_addr;
    logic [7:0]  dn_data;
    logic        execute_enable;
    logic [15:0] execute_addr;

    always #5 clk_sys = ~clk_sys;

    trs_dn_arbiter #(.DEPTH(DEPTH), .WR_GAP(WR_GAP)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .a_active(a_active), .a_wr(a_wr), .a_addr(a_addr), .a_data(a_data),
        .a_exec(a_exec), .a_exec_addr(a_exec_addr), .a_wait(a_wait),
        .b_active(b_active), .b_wr(b_wr), .b_sel(b_sel), .b_addr(b_addr),
        .b_data(b_data), .b_wait(b_wait),
        .dn_busy(dn_busy), .dn_go(dn_go), .dn_wr(dn_wr), .dn_addr(dn_addr),
        .dn_data(dn_data), .execute_enable(execute_enable),
        .execute_addr(execute_addr)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned tb_cyc   = 0;

    always @(posedge clk_sys) tb_cyc <= tb_cyc + 1;

    // ------------------------------------------------------------------
    // Reference model: byte queues, round-robin pick, strobe spacing by
    // edge arithmetic. Expectations describe the cycle after each edge.
    // ------------------------------------------------------------------
    logic [24:0] qa[$];
    logic [24:0] qb[$];
    int unsigned m_edge, m_next_ok;
    bit          m_last_b, m_pend, m_any, m_fire, m_issue, m_take_a;
    logic [15:0] m_pend_addr;
    logic [24:0] m_ent;
    logic        exp_go, exp_wr, exp_ee, exp_aw, exp_bw;
    logic [23:0] exp_addr;
    logic [7:0]  exp_data;
    logic [15:0] exp_eaddr;

    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            qa.delete(); qb.delete();
            m_edge = 0; m_next_ok = 0; m_last_b = 1; m_pend = 0; m_pend_addr = '0;
            exp_go = 0; exp_wr = 0; exp_ee = 0; exp_aw = 0; exp_bw = 0;
            exp_addr = '0; exp_data = '0; exp_eaddr = '0;
        end else begin
            m_edge++;
            m_any  = (qa.size() != 0) || (qb.size() != 0);
            m_fire = m_pend && !exp_go && !a_active && !b_active;
            exp_go = a_active || b_active || m_any || (m_edge <= m_next_ok);
            m_issue = m_any && !dn_busy && (m_edge >= m_next_ok);
            exp_wr = m_issue;
            if (m_issue) begin
                m_take_a = (qa.size() != 0) && ((qb.size() == 0) || m_last_b);
                if (m_take_a) m_ent = qa.pop_front();
                else          m_ent = qb.pop_front();
                m_last_b  = !m_take_a;
                exp_addr  = {7'h00, m_ent[24], m_ent[23:8]};
                exp_data  = m_ent[7:0];
                m_next_ok = m_edge + WR_GAP + 1;
            end
            if (a_wr && (qa.size() < DEPTH)) qa.push_back({1'b0, a_addr, a_data});
            if (b_wr && (qb.size() < DEPTH)) qb.push_back({b_sel, b_addr, b_data});
            exp_aw = (qa.size() >= DEPTH - 1);
            exp_bw = (qb.size() >= DEPTH - 1);
            exp_ee = m_fire;
            if (m_fire) exp_eaddr = m_pend_addr;
            if (a_exec) begin
                m_pend = 1; m_pend_addr = a_exec_addr;
            end else if (m_fire) begin
                m_pend = 0;
            end
        end
    end

    typedef struct {
        int unsigned cyc;
        logic [23:0] addr;
        logic [7:0]  data;
    } strobe_t;

    strobe_t     log_q[$];
    int          ee_seen;
    int unsigned ee_cyc;
    logic        ee_go;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, tb_cyc, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_strobes(input int k, input int max, input string nm);
        for (int i = 0; i < max && log_q.size() < k; i++) begin
            @(negedge clk_sys);
            #1;
        end
        chk(nm, log_q.size(), k);
    endtask

    logic [23:0] rr_exp [6];

    initial begin
        a_active = 0; a_wr = 0; a_addr = '0; a_data = '0; a_exec = 0; a_exec_addr = '0;
        b_active = 0; b_wr = 0; b_sel = 0; b_addr = '0; b_data = '0; dn_busy = 0;
        ee_seen = 0; ee_cyc = 0; ee_go = 0;
        #2 reset = 1;

        fork
            forever begin
                @(negedge clk_sys);
                chk("dn_go", dn_go, exp_go);
                chk("dn_wr", dn_wr, exp_wr);
                chk("dn_addr", dn_addr, exp_addr);
                chk("dn_data", dn_data, exp_data);
                chk("a_wait", a_wait, exp_aw);
                chk("b_wait", b_wait, exp_bw);
                chk("execute_enable", execute_enable, exp_ee);
                chk("execute_addr", execute_addr, exp_eaddr);
                if (dn_wr) log_q.push_back('{tb_cyc, dn_addr, dn_data});
                if (execute_enable) begin
                    ee_seen++; ee_cyc = tb_cyc; ee_go = dn_go;
                end
            end
        join_none

        step(3);
        reset = 0;
        chk("rst_dn_go", dn_go, 0);
        chk("rst_dn_addr", dn_addr, 0);
        chk("rst_a_wait", a_wait, 0);
        step(2);

        // A only: one byte to CPU space
        a_active = 1; a_addr = 16'h4000; a_data = 8'h42; a_wr = 1;
        step(1);
        a_wr = 0;
        wait_strobes(1, 10, "a_only_strobe");
        if (log_q.size() >= 1) begin
            chk("a_only_addr", log_q[0].addr, 24'h004000);
            chk("a_only_data", log_q[0].data, 8'h42);
        end
        chk("a_only_go", dn_go, 1);
        a_active = 0;
        step(10);
        log_q.delete();

        // B to cassette space
        b_active = 1; b_sel = 1; b_addr = 16'h0010; b_data = 8'hA5; b_wr = 1;
        step(1);
        b_wr = 0;
        wait_strobes(1, 10, "b_cas_strobe");
        if (log_q.size() >= 1) begin
            chk("b_cas_addr", log_q[0].addr, 24'h010010);
            chk("b_cas_data", log_q[0].data, 8'hA5);
        end
        b_active = 0; b_sel = 0;
        step(10);
        log_q.delete();

        // Round-robin with three bytes in each FIFO
        dn_busy = 1; a_active = 1; b_active = 1;
        for (int i = 0; i < 3; i++) begin
            a_wr = 1; a_addr = 16'h1000 + 16'(i); a_data = 8'h10 + 8'(i);
            b_wr = 1; b_addr = 16'h2000 + 16'(i); b_data = 8'h20 + 8'(i);
            step(1);
        end
        a_wr = 0; b_wr = 0; dn_busy = 0;
        rr_exp = '{24'h001000, 24'h002000, 24'h001001, 24'h002001, 24'h001002, 24'h002002};
        wait_strobes(6, 40, "rr_count");
        for (int i = 0; i < 6 && i < log_q.size(); i++) begin
            chk($sformatf("rr_addr%0d", i), log_q[i].addr, rr_exp[i]);
            if (i > 0) chk($sformatf("rr_spacing%0d", i), log_q[i].cyc - log_q[i-1].cyc, 4);
        end
        a_active = 0; b_active = 0;
        step(10);
        log_q.delete();

        // Fill A while the RAM side is held off; fifth byte is dropped
        dn_busy = 1; a_active = 1;
        for (int i = 0; i < 5; i++) begin
            a_wr = 1; a_addr = 16'h3000 + 16'(i); a_data = 8'h30 + 8'(i);
            step(1);
            chk($sformatf("a_wait_fill%0d", i), a_wait, (i >= 2));
        end
        a_wr = 0;
        step(2);
        dn_busy = 0;
        wait_strobes(4, 40, "fill_strobes");
        step(20);
        chk("fill_drop_count", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++)
            chk($sformatf("fill_addr%0d", i), log_q[i].addr, 24'h003000 + 24'(i));
        a_active = 0;
        step(10);
        log_q.delete();

        // dn_busy held for ten cycles with a byte pending
        dn_busy = 1; b_active = 1; b_addr = 16'h0055; b_data = 8'h77; b_wr = 1;
        step(1);
        b_wr = 0;
        step(9);
        chk("busy_hold", log_q.size(), 0);
        begin
            int unsigned rel;
            rel = tb_cyc;
            dn_busy = 0;
            wait_strobes(1, 10, "busy_release");
            if (log_q.size() >= 1) chk("busy_release_lat", log_q[0].cyc - rel, 1);
        end
        b_active = 0;
        step(10);
        log_q.delete();

        // Execute deferred until the transfer is over; second request wins
        ee_seen = 0;
        a_active = 1; a_exec = 1; a_exec_addr = 16'h1111;
        a_wr = 1; a_addr = 16'h6000; a_data = 8'h60;
        step(1);
        a_exec = 0; a_addr = 16'h6001; a_data = 8'h61;
        step(1);
        a_wr = 0; a_exec = 1; a_exec_addr = 16'h5200;
        step(1);
        a_exec = 0;
        step(2);
        a_active = 0;
        for (int i = 0; i < 40 && ee_seen == 0; i++) step(1);
        chk("exec_seen", ee_seen, 1);
        chk("exec_addr", execute_addr, 16'h5200);
        chk("exec_go_low", ee_go, 0);
        chk("exec_strobes", log_q.size(), 2);
        if (log_q.size() == 2) chk("exec_after_last", (ee_cyc > log_q[1].cyc + WR_GAP), 1);
        step(10);
        log_q.delete();

        // Reset mid-transfer discards bytes and the pending execute
        ee_seen = 0;
        dn_busy = 1; a_active = 1; a_exec = 1; a_exec_addr = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            a_wr = 1; a_addr = 16'h7000 + 16'(i); a_data = 8'h70 + 8'(i);
            step(1);
            a_exec = 0;
        end
        a_wr = 0;
        reset = 1;
        step(2);
        reset = 0; a_active = 0; dn_busy = 0;
        chk("rst_mid_wait", a_wait, 0);
        step(20);
        chk("rst_mid_no_strobe", log_q.size(), 0);
        chk("rst_mid_no_exec", ee_seen, 0);

        step(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
